// File: rtl/io_stage_memory_request_controller_if.sv
// ----------------------------------------------------------------------------
// io_stage_memory_request_controller_if
//
// Bundles every signal of the IO-stage memory request controller except the
// clock and reset: the executing-stage issue port, the IO-stage result port,
// the flush input and the SRAM-like data bus.
//
// Modports:
//   master : the controller itself (drives issue_ready, result_*, busy, data_*)
//   slave  : the surrounding pipeline and memory (drive mem_*, flush,
//            result_ready, data_address_ok, data_data_ok, data_read_data)
//
// Handshakes: issue transfers when mem_valid & issue_ready & ~flush on a rising
// clock edge; result transfers when result_valid & result_ready; the memory
// accepts a request when data_request & data_address_ok, and returns one
// response (or store acknowledge) with data_data_ok. Producers hold their
// payload stable while their valid/request is high and the transfer has not
// yet happened.
// ----------------------------------------------------------------------------
interface io_stage_memory_request_controller_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // executing-stage issue port
    logic                     mem_valid;
    logic                     mem_write;
    logic [1:0]               mem_size;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH/8-1:0]  mem_write_strobe;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic                     issue_ready;

    // exception / eret flush
    logic                     flush;

    // IO-stage result port
    logic                     result_valid;
    logic [DATA_WIDTH-1:0]    result_data;
    logic                     result_ready;
    logic                     busy;

    // SRAM-like data bus
    logic                     data_request;
    logic                     data_write;
    logic [1:0]               data_size;
    logic [ADDRESS_WIDTH-1:0] data_address;
    logic [DATA_WIDTH/8-1:0]  data_write_strobe;
    logic [DATA_WIDTH-1:0]    data_write_data;
    logic                     data_address_ok;
    logic                     data_data_ok;
    logic [DATA_WIDTH-1:0]    data_read_data;

    modport master (
        input  mem_valid, mem_write, mem_size, mem_address,
               mem_write_strobe, mem_write_data,
        output issue_ready,
        input  flush,
        output result_valid, result_data,
        input  result_ready,
        output busy,
        output data_request, data_write, data_size, data_address,
               data_write_strobe, data_write_data,
        input  data_address_ok, data_data_ok, data_read_data
    );

    modport slave (
        output mem_valid, mem_write, mem_size, mem_address,
               mem_write_strobe, mem_write_data,
        input  issue_ready,
        output flush,
        input  result_valid, result_data,
        output result_ready,
        input  busy,
        input  data_request, data_write, data_size, data_address,
               data_write_strobe, data_write_data,
        output data_address_ok, data_data_ok, data_read_data
    );
endinterface

// File: rtl/io_stage_memory_request_controller.sv
// ----------------------------------------------------------------------------
// io_stage_memory_request_controller
//
// Sequences one data-memory access at a time for the IO (memory) stage:
// takes a load/store from the executing stage, presents it on the SRAM-like
// bus until the address is accepted, waits for the response, then holds the
// completion for the IO stage until it is consumed. A flush cancels the
// access; any response still owed by the memory is absorbed and dropped so
// stale load data never reaches writeback.
//
// Ports:
//   clock    : core clock, all state updates on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : controller side (master modport) of the issue/result/data bus
//   state_o  : current FSM state (IDLE=0, REQUEST=1, WAIT=2, HOLD=3, DISCARD=4)
// ----------------------------------------------------------------------------
module io_stage_memory_request_controller #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    io_stage_memory_request_controller_if.master  bus,
    output logic [2:0]                            state_o
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    state_t                   state_q;
    logic                     cancel_q;
    logic                     data_request_q;
    logic                     write_q;
    logic [1:0]               size_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [STROBE_WIDTH-1:0]  strobe_q;
    logic [DATA_WIDTH-1:0]    write_data_q;
    logic                     result_valid_q;
    logic [DATA_WIDTH-1:0]    result_data_q;

    logic accept;
    logic cancelled;

    assign accept    = bus.mem_valid & (state_q == ST_IDLE) & ~bus.flush;
    // A flush in the very cycle the address is accepted counts as well as an
    // earlier one remembered in cancel_q.
    assign cancelled = cancel_q | bus.flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cancel_q       <= 1'b0;
            data_request_q <= 1'b0;
            write_q        <= 1'b0;
            size_q         <= '0;
            address_q      <= '0;
            strobe_q       <= '0;
            write_data_q   <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        write_q        <= bus.mem_write;
                        size_q         <= bus.mem_size;
                        address_q      <= bus.mem_address;
                        strobe_q       <= bus.mem_write_strobe;
                        write_data_q   <= bus.mem_write_data;
                        data_request_q <= 1'b1;
                        cancel_q       <= 1'b0;
                        state_q        <= ST_REQUEST;
                    end
                end

                // The request cannot be withdrawn once raised, so a flush here
                // only marks the access as cancelled.
                ST_REQUEST: begin
                    if (bus.data_address_ok) begin
                        data_request_q <= 1'b0;
                        cancel_q       <= 1'b0;
                        if (bus.data_data_ok) begin
                            // address and response in one cycle: complete now
                            if (cancelled) begin
                                state_q <= ST_IDLE;
                            end else begin
                                result_data_q  <= write_q ? '0 : bus.data_read_data;
                                result_valid_q <= 1'b1;
                                state_q        <= ST_HOLD;
                            end
                        end else begin
                            state_q <= cancelled ? ST_DISCARD : ST_WAIT;
                        end
                    end else if (bus.flush) begin
                        cancel_q <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (bus.data_data_ok) begin
                        if (bus.flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            result_data_q  <= write_q ? '0 : bus.data_read_data;
                            result_valid_q <= 1'b1;
                            state_q        <= ST_HOLD;
                        end
                    end else if (bus.flush) begin
                        state_q <= ST_DISCARD;
                    end
                end

                // Flush wins over result_ready; both simply retire the result.
                ST_HOLD: begin
                    if (bus.flush || bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end

                // Absorb the response still owed by the memory.
                ST_DISCARD: begin
                    if (bus.data_data_ok) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q        <= ST_IDLE;
                    data_request_q <= 1'b0;
                    result_valid_q <= 1'b0;
                    cancel_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue_ready       = (state_q == ST_IDLE);
    assign bus.busy              = (state_q != ST_IDLE);
    assign bus.result_valid      = result_valid_q;
    assign bus.result_data       = result_data_q;
    assign bus.data_request      = data_request_q;
    assign bus.data_write        = write_q;
    assign bus.data_size         = size_q;
    assign bus.data_address      = address_q;
    assign bus.data_write_strobe = strobe_q;
    assign bus.data_write_data   = write_data_q;
    assign state_o               = state_q;

endmodule
